fir_mac_sequencer: RTL

- Control sequencer for the FIR filter's single shared multiply-accumulate datapath.
- Accepts one input sample per handshake and writes it into a circular delay-line RAM. Then issues one coefficient/sample read pair per tap, and drives the MAC enable and clear strobes. Captures the accumulator and presents the result on a valid/ready output.
- Sits between the AXI4-Lite register block, which supplies cfg_*, and the FIR datapath: delay RAM, coefficient RAM and MAC.

---
 rtl/fir_mac_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: sequencer for the FIR filter's shared MAC datapath.
// Writes samples into a circular delay line, issues tap reads, returns the sum.
module fir_mac_sequencer #(
  parameter int NTAPS_MAX = 32,
  parameter int AW        = 5,
  parameter int DW        = 16,
  parameter int ACCW      = 40
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic            cfg_enable,
  input  logic [AW:0]     cfg_ntaps,
  input  logic            cfg_flush,
  input  logic            s_valid,
  input  logic [DW-1:0]   s_data,
  output logic            s_ready,
  output logic            dl_we,
  output logic [AW-1:0]   dl_waddr,
  output logic [DW-1:0]   dl_wdata,
  output logic [AW-1:0]   dl_raddr,
  output logic [AW-1:0]   coef_raddr,
  output logic            mac_en,
  output logic            mac_clr,
  input  logic [ACCW-1:0] acc_in,
  output logic            m_valid,
  output logic [ACCW-1:0] m_data,
  input  logic            m_ready,
  output logic            busy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CAPT,
    S_OUT
  } state_t;

  state_t        state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] base;
  logic [AW-1:0] k;
  logic [AW-1:0] nm1;
  logic [AW-1:0] nm1_next;
  logic          in_init;
  logic          in_idle;
  logic          in_run;
  logic          accept;

  assign in_init = (state == S_INIT);
  assign in_idle = (state == S_IDLE);
  assign in_run  = (state == S_RUN);

  // Flush wins over accept, so ready drops while it is asserted.
  assign s_ready = in_idle & cfg_enable & ~cfg_flush;
  assign accept  = s_ready & s_valid;
  assign busy    = ~in_idle;

  // Delay-line write port: clear sweep in INIT, new sample on accept.
  // ARESET gating keeps the write strobe quiet while reset is held.
  assign dl_we    = (in_init & ~ARESET) | accept;
  assign dl_waddr = in_init ? k : wptr;
  assign dl_wdata = accept ? s_data : '0;

  // Tap k reads the sample k positions older than the newest one.
  assign dl_raddr   = in_run ? (base - k) : '0;
  assign coef_raddr = in_run ? k : '0;

  // Tap count clamp: zero means one tap, oversize means full depth.
  always_comb begin
    nm1_next = cfg_ntaps[AW-1:0] - AW'(1);
    if (cfg_ntaps == '0)
      nm1_next = '0;
    else if (cfg_ntaps > (AW+1)'(NTAPS_MAX))
      nm1_next = AW'(NTAPS_MAX - 1);
  end

  // Control FSM with the issue pipeline and result register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= S_INIT;
      wptr    <= '0;
      base    <= '0;
      k       <= '0;
      nm1     <= '0;
      mac_en  <= 1'b0;
      mac_clr <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      mac_en  <= in_run;
      mac_clr <= in_run & (k == '0);
      unique case (state)
        S_INIT: begin
          if (k == AW'(NTAPS_MAX - 1)) begin
            k     <= '0;
            wptr  <= '0;
            state <= S_IDLE;
          end else begin
            k <= k + AW'(1);
          end
        end
        S_IDLE: begin
          if (cfg_flush) begin
            k     <= '0;
            state <= S_INIT;
          end else if (accept) begin
            base  <= wptr;
            nm1   <= nm1_next;
            wptr  <= wptr + AW'(1);
            k     <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (k == nm1)
            state <= S_DRAIN;
          else
            k <= k + AW'(1);
        end
        S_DRAIN: state <= S_CAPT;
        S_CAPT: begin
          m_data  <= acc_in;
          m_valid <= 1'b1;
          state   <= S_OUT;
        end
        S_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
